serial_digit_adder: RTL
=======================

Name: serial_digit_adder

Overview:
- Multi-cycle, parametrised successor to the team's single-bit full-adder cell.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, with the carry held in a register between digits.
- Start/busy/done handshake; flags for carry-out and signed overflow.
- Area-lean arithmetic unit for the BCD/binary conversion datapaths; DIGIT trades latency against adder width.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH. N = WIDTH/DIGIT digit cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- sub  input  1  0 = add, 1 = subtract (a - b).
- cin  input  1  add: carry-in; subtract: borrow-in (result a - b - cin).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result; held until next acceptance.
- cout  output  1  raw carry out of MSB. In subtract mode, cout=0 means borrow.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; busy=0, done=0, sum=0, cout=0, ovf=0, internal operand/carry/digit counter=0. Reset mid-operation aborts with no done pulse.
- States:
  - IDLE: if start=1 at an edge, capture a, b^{WIDTH{sub}} and carry0 = cin ^ sub; clear the digit counter; go to RUN; busy=1.
  - RUN: each edge adds the current DIGIT-wide slice with a ripple of full-adder cells plus the carry register. It writes that slice of sum, updates carry, and increments the counter.
  - Last digit (counter = N-1): the edge processing it returns the FSM to IDLE and sets busy=0, done=1, cout=final carry, ovf = carry into MSB XOR carry out of MSB.
- Latency: start accepted at edge 0; digits processed at edges 1..N; done high in the cycle after edge N. N=4 at defaults.
- done clears at the next edge unless another completion occurs; it never stays high for two consecutive cycles.
- a, b, sub, cin are sampled only at acceptance; changes while busy=1 have no effect.
- start while busy=1 is ignored and not queued.
- start held high: the next operation is accepted at edge N+1, the first edge with busy=0. Throughput is one result per N+1 cycles.
- During RUN, sum is undefined for observers; sum/cout/ovf are only meaningful from done onward. They hold until the next acceptance, which clears sum to 0 at capture.
- DIGIT=WIDTH (N=1): single RUN cycle, done one cycle after acceptance.
- DIGIT=1: pure bit-serial operation, N=WIDTH.
- Carry chain is WIDTH-exact; no wrap-around beyond MSB except via cout.

Test Plan:
- Defaults, add: a=0x1234, b=0x0FED, cin=0, sub=0 → busy high 4 cycles, done after edge 4, sum=0x2221, cout=0, ovf=0.
- Add boundaries:
  - 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
  - 0xFFFF+0xFFFF with cin=1 → sum=0xFFFF, cout=1.
- Subtract:
  - 0x0005-0x0007 → sum=0xFFFE, cout=0 (borrow), ovf=0.
  - 0x8000-0x0001 → sum=0x7FFF, cout=1, ovf=1.
  - 0x0010-0x0001 with cin=1 → sum=0x000E.
- Handshake: pulse start with different operands at edges 2 and 3 of a busy op → ignored, first result intact. start held high → done every 5 cycles, each result matching operands present at its acceptance edge.
- Reset mid-op: rst_n low during RUN digit 2 → busy, done, sum, cout, ovf = 0 immediately with no done pulse; a fresh start then completes normally.
- Parameter sweep:
  - WIDTH=8, DIGIT=8: 0x7F+0x01 → done 1 cycle after start, sum=0x80, ovf=1.
  - WIDTH=8, DIGIT=1: same operands → done after 8 cycles, same result.
  - Random compare of 1000 ops vs. reference model for both settings.

Source files
------------

// File: rtl/serial_digit_adder_if.sv
// Request/result bundle for serial_digit_adder: operands and mode in, status and result out.
interface serial_digit_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_digit_adder.sv
// Digit-serial add/subtract: DIGIT bits per clock, LSB digit first, carry held between digits.
// Subtract is a + ~b + 1 with the borrow-in folded into the initial carry.
module sda_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_digit_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_digit_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [31:0]      base;
    logic [DIGIT-1:0] a_dig, b_dig, s_dig;
    logic [DIGIT:0]   c_chain;
    logic             last;

    assign base  = 32'(cnt_q) * DIGIT;
    assign a_dig = a_q[base +: DIGIT];
    assign b_dig = b_q[base +: DIGIT];
    assign last  = (cnt_q == CW'(N - 1));

    assign c_chain[0] = carry_q;

    sda_fa_cell u_fa [DIGIT-1:0] (
        .a_i (a_dig),
        .b_i (b_dig),
        .c_i (c_chain[DIGIT-1:0]),
        .s_o (s_dig),
        .c_o (c_chain[DIGIT:1])
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: DIGIT] = s_dig;
                carry_d = c_chain[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    // Overflow compares the carries into and out of the MSB cell.
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cout_d  = c_chain[DIGIT];
                    ovf_d   = c_chain[DIGIT-1] ^ c_chain[DIGIT];
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
